// File: rtl/stage_memory.sv
// rtl/stage_memory.sv - MEM stage: EX/MEM register, byte/half/word data memory, load extension, forwarding tap
// Optional store trace compiled only when MEM_TRACE_EN is defined.
`ifndef MEM_TYPE_LEN
`define MEM_TYPE_LEN 2
`endif
`ifndef MEM_TYPE_BYTE
`define MEM_TYPE_BYTE 2'd0
`endif
`ifndef MEM_TYPE_HALF
`define MEM_TYPE_HALF 2'd1
`endif
`ifndef MEM_TYPE_WORD
`define MEM_TYPE_WORD 2'd2
`endif

module stage_memory #(
   parameter int ADDR_W = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     ex_valid,
   input  logic [31:0]              ex_pc,
   input  logic [31:0]              ex_alu_result,
   input  logic [31:0]              ex_store_data,
   input  logic                     ex_mem_write,
   input  logic                     ex_mem_read,
   input  logic [`MEM_TYPE_LEN-1:0] ex_mem_type,
   input  logic                     ex_load_signed,
   input  logic                     ex_unaligned,
   input  logic                     ex_reg_write,
   input  logic [4:0]               ex_dst,
   output logic [31:0]              mem_pc,
   output logic                     mem_reg_write,
   output logic [4:0]               mem_dst,
   output logic [31:0]              mem_result,
   output logic                     fwd_valid,
   output logic                     store_fault
);

   localparam int DEPTH = 1 << ADDR_W;

   logic                     valid_q, valid_d;
   logic [31:0]              pc_q, pc_d;
   logic [31:0]              alu_q, alu_d;
   logic [31:0]              store_q, store_d;
   logic                     mem_write_q, mem_write_d;
   logic                     mem_read_q, mem_read_d;
   logic [`MEM_TYPE_LEN-1:0] mem_type_q, mem_type_d;
   logic                     load_signed_q, load_signed_d;
   logic                     unaligned_q, unaligned_d;
   logic                     reg_write_q, reg_write_d;
   logic [4:0]               dst_q, dst_d;

   logic [31:0]              mem_q [DEPTH];

   logic                     in_range;
   logic [ADDR_W-1:0]        word_idx;
   logic [31:0]              rd_word;
   logic [31:0]              load_data;
   logic [7:0]               ld_byte;
   logic [15:0]              ld_half;
   logic                     wr_en;
   logic [31:0]              wr_word;

   always_comb begin
      valid_d       = 1'b0;
      pc_d          = '0;
      alu_d         = '0;
      store_d       = '0;
      mem_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_type_d    = '0;
      load_signed_d = 1'b0;
      unaligned_d   = 1'b0;
      reg_write_d   = 1'b0;
      dst_d         = '0;
      if (!flush && ex_valid) begin
         valid_d       = 1'b1;
         pc_d          = ex_pc;
         alu_d         = ex_alu_result;
         store_d       = ex_store_data;
         mem_write_d   = ex_mem_write;
         mem_read_d    = ex_mem_read;
         mem_type_d    = ex_mem_type;
         load_signed_d = ex_load_signed;
         unaligned_d   = ex_unaligned;
         reg_write_d   = ex_reg_write;
         dst_d         = ex_dst;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q       <= 1'b0;
         pc_q          <= '0;
         alu_q         <= '0;
         store_q       <= '0;
         mem_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_type_q    <= '0;
         load_signed_q <= 1'b0;
         unaligned_q   <= 1'b0;
         reg_write_q   <= 1'b0;
         dst_q         <= '0;
      end else begin
         valid_q       <= valid_d;
         pc_q          <= pc_d;
         alu_q         <= alu_d;
         store_q       <= store_d;
         mem_write_q   <= mem_write_d;
         mem_read_q    <= mem_read_d;
         mem_type_q    <= mem_type_d;
         load_signed_q <= load_signed_d;
         unaligned_q   <= unaligned_d;
         reg_write_q   <= reg_write_d;
         dst_q         <= dst_d;
      end
   end

   assign in_range = (alu_q[31:ADDR_W+2] == '0);
   assign word_idx = alu_q[ADDR_W+1:2];
   assign rd_word  = in_range ? mem_q[word_idx] : 32'h0;
   assign ld_byte  = rd_word[{alu_q[1:0], 3'b000} +: 8];
   assign ld_half  = rd_word[{alu_q[1], 4'b0000} +: 16];

   always_comb begin
      load_data = rd_word;
      case (mem_type_q)
         `MEM_TYPE_BYTE: load_data = load_signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
         `MEM_TYPE_HALF: load_data = load_signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
         default:        load_data = rd_word;
      endcase
   end

   // Store merges into the current word so untouched byte lanes keep their value.
   always_comb begin
      wr_en   = valid_q && mem_write_q && !unaligned_q && in_range;
      wr_word = rd_word;
      case (mem_type_q)
         `MEM_TYPE_BYTE: wr_word[{alu_q[1:0], 3'b000} +: 8] = store_q[7:0];
         `MEM_TYPE_HALF: wr_word[{alu_q[1], 4'b0000} +: 16] = store_q[15:0];
         default:        wr_word = store_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[word_idx] <= wr_word;
      end
   end

`ifdef MEM_TRACE_EN
   always @(posedge clk) begin
      if (!reset && wr_en)
         $display("%d@%h: *%h <= %h", $time, pc_q, {alu_q[31:2], 2'b00}, wr_word);
   end
`endif

   assign mem_pc        = pc_q;
   assign mem_reg_write = reg_write_q && valid_q;
   assign mem_dst       = dst_q;
   assign mem_result    = (valid_q && mem_read_q) ? load_data : alu_q;
   assign fwd_valid     = mem_reg_write && (dst_q != 5'd0);
   assign store_fault   = valid_q && mem_write_q && (unaligned_q || !in_range);

endmodule

// File: tb/tb_stage_memory.sv
// tb/tb_stage_memory.sv - self-checking bench for stage_memory against a byte-array reference model
`ifndef MEM_TYPE_LEN
`define MEM_TYPE_LEN 2
`endif
`ifndef MEM_TYPE_BYTE
`define MEM_TYPE_BYTE 2'd0
`endif
`ifndef MEM_TYPE_HALF
`define MEM_TYPE_HALF 2'd1
`endif
`ifndef MEM_TYPE_WORD
`define MEM_TYPE_WORD 2'd2
`endif

module tb_stage_memory;

   localparam int AW     = 12;
   localparam int NBYTES = 4 << AW;
   localparam logic [1:0] MB = `MEM_TYPE_BYTE;
   localparam logic [1:0] MH = `MEM_TYPE_HALF;
   localparam logic [1:0] MW = `MEM_TYPE_WORD;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic        ex_mem_write;
   logic        ex_mem_read;
   logic [1:0]  ex_mem_type;
   logic        ex_load_signed;
   logic        ex_unaligned;
   logic        ex_reg_write;
   logic [4:0]  ex_dst;
   logic [31:0] mem_pc;
   logic        mem_reg_write;
   logic [4:0]  mem_dst;
   logic [31:0] mem_result;
   logic        fwd_valid;
   logic        store_fault;

   int n_pass = 0;
   int n_tot  = 0;

   stage_memory #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_mem_type(ex_mem_type),
      .ex_load_signed(ex_load_signed), .ex_unaligned(ex_unaligned),
      .ex_reg_write(ex_reg_write), .ex_dst(ex_dst), .mem_pc(mem_pc),
      .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
      .fwd_valid(fwd_valid), .store_fault(store_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      logic [31:0] pc, alu, sd;
      bit          wr, rd, sg, un, rw;
      logic [1:0]  mt;
      logic [4:0]  dst;
   } instr_t;

   instr_t     cur;
   logic [7:0] bm [NBYTES];
   bit         ready = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tot++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   function automatic int span(input logic [1:0] mt);
      return (mt == MB) ? 1 : (mt == MH) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] mt, input bit sg);
      int n, b;
      logic [31:0] v;
      if (a >= NBYTES) return 32'h0;
      n = span(mt);
      b = int'(a) & ~(n - 1);
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = bm[b + k];
      if (sg && v[8*n-1]) for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      cur = '{default: '0};
      for (int i = 0; i < NBYTES; i++) bm[i] = 8'h00;
   endtask

   task automatic model_clock();
      int n, b;
      if (cur.v && cur.wr && !cur.un && cur.alu < NBYTES) begin
         n = span(cur.mt);
         b = int'(cur.alu) & ~(n - 1);
         for (int k = 0; k < n; k++) bm[b + k] = cur.sd[8*k +: 8];
      end
      if (flush || !ex_valid) cur = '{default: '0};
      else cur = '{v: 1'b1, pc: ex_pc, alu: ex_alu_result, sd: ex_store_data,
                   wr: ex_mem_write, rd: ex_mem_read, sg: ex_load_signed,
                   un: ex_unaligned, rw: ex_reg_write, mt: ex_mem_type, dst: ex_dst};
   endtask

   always @(negedge clk) begin
      if (ready) begin
         chk("mem_pc", mem_pc, cur.pc);
         chk("mem_reg_write", {31'h0, mem_reg_write}, {31'h0, cur.v & cur.rw});
         chk("mem_dst", {27'h0, mem_dst}, {27'h0, cur.dst});
         chk("mem_result", mem_result, (cur.v && cur.rd) ? model_load(cur.alu, cur.mt, cur.sg) : cur.alu);
         chk("fwd_valid", {31'h0, fwd_valid}, {31'h0, cur.v & cur.rw & (cur.dst != 0)});
         chk("store_fault", {31'h0, store_fault},
             {31'h0, cur.v & cur.wr & (cur.un | (cur.alu >= NBYTES))});
      end
   end

   logic [31:0] pc_ctr = 32'h0000_1000;

   task automatic issue(input bit v, input bit fl, input bit wr, input bit rd, input logic [1:0] mt,
                        input bit sg, input bit un, input bit rw, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] sd);
      ex_valid = v; flush = fl; ex_mem_write = wr; ex_mem_read = rd; ex_mem_type = mt;
      ex_load_signed = sg; ex_unaligned = un; ex_reg_write = rw; ex_dst = dst;
      ex_alu_result = alu; ex_store_data = sd; ex_pc = pc_ctr;
      pc_ctr += 4;
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d, input bit un = 0);
      issue(1, 0, 1, 0, MW, 0, un, 0, 0, a, d);
   endtask
   task automatic st(input logic [1:0] mt, input logic [31:0] a, input logic [31:0] d);
      issue(1, 0, 1, 0, mt, 0, 0, 0, 0, a, d);
   endtask
   task automatic ld(input logic [1:0] mt, input bit sg, input logic [31:0] a);
      issue(1, 0, 0, 1, mt, sg, 0, 1, 5'd8, a, 32'h0);
   endtask

   initial begin
      reset = 1; flush = 0; ex_valid = 0; ex_pc = 0; ex_alu_result = 0; ex_store_data = 0;
      ex_mem_write = 0; ex_mem_read = 0; ex_mem_type = MW; ex_load_signed = 0;
      ex_unaligned = 0; ex_reg_write = 0; ex_dst = 0;
      model_reset();
      ready = 1;
      repeat (2) @(negedge clk);
      reset = 0;

      // Reset mid-run aborts a store pending in MEM
      sw(32'h20, 32'hDEADBEEF);
      #2 reset = 1;
      model_reset();
      #1;
      chk("rst_pc", mem_pc, 32'h0);
      chk("rst_result", mem_result, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      ld(MW, 0, 32'h0);
      chk("lw0_after_rst", mem_result, 32'h0);
      ld(MW, 0, 32'h20);
      chk("lw20_aborted", mem_result, 32'h0);

      sw(32'h10, 32'h12345678);
      ld(MW, 0, 32'h10);
      chk("lw10", mem_result, 32'h12345678);

      st(MB, 32'h11, 32'h000000AB);
      ld(MW, 0, 32'h10);
      chk("sb_word", mem_result, 32'h1234AB78);
      ld(MB, 1, 32'h11);
      chk("lb", mem_result, 32'hFFFFFFAB);
      ld(MB, 0, 32'h11);
      chk("lbu", mem_result, 32'h000000AB);

      st(MH, 32'h12, 32'h00008001);
      ld(MW, 0, 32'h10);
      chk("sh_word", mem_result, 32'h8001AB78);
      ld(MH, 1, 32'h12);
      chk("lh", mem_result, 32'hFFFF8001);
      ld(MH, 0, 32'h12);
      chk("lhu", mem_result, 32'h00008001);
      ld(MW, 0, 32'h13);
      chk("lw_unaligned", mem_result, 32'h8001AB78);

      sw(32'h13, 32'hFFFFFFFF, 1);
      chk("fault_unal", {31'h0, store_fault}, 32'h1);
      sw(32'h1 << (AW + 2), 32'hCAFEF00D);
      chk("fault_range", {31'h0, store_fault}, 32'h1);
      ld(MW, 0, 32'h10);
      chk("mem_unchanged", mem_result, 32'h8001AB78);
      ld(MW, 0, 32'h1 << (AW + 2));
      chk("lw_out_of_range", mem_result, 32'h0);
      ld(MW, 0, 32'h0);
      chk("word0_unchanged", mem_result, 32'h0);

      issue(1, 0, 0, 0, MW, 0, 0, 1, 5'd5, 32'h55, 32'h0);
      chk("alu_fwd", {31'h0, fwd_valid}, 32'h1);
      chk("alu_result", mem_result, 32'h55);
      issue(1, 0, 0, 0, MW, 0, 0, 1, 5'd0, 32'h66, 32'h0);
      chk("dst0_fwd", {31'h0, fwd_valid}, 32'h0);
      issue(1, 1, 0, 0, MW, 0, 0, 1, 5'd5, 32'h77, 32'h0);
      chk("flush_rw", {31'h0, mem_reg_write}, 32'h0);
      chk("flush_fwd", {31'h0, fwd_valid}, 32'h0);
      chk("flush_result", mem_result, 32'h0);

      // Store in MEM still commits while a flush bubbles the incoming instruction
      sw(32'h30, 32'hA5A5_5A5A);
      issue(1, 1, 0, 1, MW, 0, 0, 1, 5'd3, 32'h30, 32'h0);
      ld(MW, 0, 32'h30);
      chk("store_under_flush", mem_result, 32'hA5A5_5A5A);
      issue(0, 0, 0, 0, MW, 0, 0, 0, 0, 32'h0, 32'h0);

      ready = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
